// File: rtl/mem_write_dispatcher.sv
// Store-side dispatcher: routes one datapath store to RAM, timer or HD.
// RAM/timer writes are one-cycle pulses; HD writes use req/ack with a timeout and stall the pipeline.
module mem_write_dispatcher #(
  parameter int HD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_write,
  input  logic [1:0]       sel,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic             ram_we,
  output logic [31:0]      ram_addr,
  output logic [31:0]      ram_wdata,
  output logic             timer_we,
  output logic [31:0]      timer_wdata,
  output logic             hd_req,
  output logic [31:0]      hd_addr,
  output logic [31:0]      hd_wdata,
  input  logic             hd_ack,
  output logic             stall,
  output logic             err,
  output logic [CNT_W-1:0] wr_count,
  output logic             state_dbg
);

  // HD handshake: hd_req rises the cycle after the request is accepted and stays
  // high with hd_addr/hd_wdata frozen until a cycle where hd_ack = 1 is sampled
  // (transfer done) or the timeout expires (abort); hd_ack is ignored otherwise.
  typedef enum logic {IDLE = 1'b0, HD_WAIT = 1'b1} state_t;

  localparam logic [15:0] TO_LAST = 16'(HD_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] tcnt, tcnt_nxt;
  logic        ram_we_nxt, timer_we_nxt, err_nxt;
  logic        ram_ld, timer_ld, hd_ld, cnt_inc;

  always_comb begin
    state_nxt    = state;
    tcnt_nxt     = tcnt;
    ram_we_nxt   = 1'b0;
    timer_we_nxt = 1'b0;
    ram_ld       = 1'b0;
    timer_ld     = 1'b0;
    hd_ld        = 1'b0;
    cnt_inc      = 1'b0;
    err_nxt      = err;
    case (state)
      IDLE: begin
        if (mem_write) begin
          case (sel)
            2'b01: begin
              ram_we_nxt = 1'b1;
              ram_ld     = 1'b1;
              cnt_inc    = 1'b1;
            end
            2'b10: begin
              timer_we_nxt = 1'b1;
              timer_ld     = 1'b1;
              cnt_inc      = 1'b1;
            end
            2'b11: begin
              hd_ld     = 1'b1;
              tcnt_nxt  = 16'd0;
              state_nxt = HD_WAIT;
            end
            default: err_nxt = 1'b1;
          endcase
        end
      end
      HD_WAIT: begin
        // An ack arriving on the timeout cycle still counts as success.
        if (hd_ack) begin
          state_nxt = IDLE;
          cnt_inc   = 1'b1;
        end else if (tcnt == TO_LAST) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else begin
          tcnt_nxt = tcnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tcnt        <= 16'd0;
      ram_we      <= 1'b0;
      ram_addr    <= 32'd0;
      ram_wdata   <= 32'd0;
      timer_we    <= 1'b0;
      timer_wdata <= 32'd0;
      hd_addr     <= 32'd0;
      hd_wdata    <= 32'd0;
      err         <= 1'b0;
      wr_count    <= '0;
    end else begin
      state    <= state_nxt;
      tcnt     <= tcnt_nxt;
      ram_we   <= ram_we_nxt;
      timer_we <= timer_we_nxt;
      err      <= err_nxt;
      if (ram_ld) begin
        ram_addr  <= addr;
        ram_wdata <= wdata;
      end
      if (timer_ld) timer_wdata <= wdata;
      if (hd_ld) begin
        hd_addr  <= addr;
        hd_wdata <= wdata;
      end
      if (cnt_inc) wr_count <= wr_count + CNT_W'(1);
    end
  end

  assign hd_req    = (state == HD_WAIT);
  // The request-cycle term holds the datapath before the HD transaction has started.
  assign stall     = (state == HD_WAIT) || ((state == IDLE) && mem_write && (sel == 2'b11));
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_write_dispatcher.sv
// Self-checking bench for mem_write_dispatcher: directed scenarios plus randomized
// traffic against a transaction-level model, with a scoreboard monitor on the write ports.
module tb_mem_write_dispatcher;
  localparam int T  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          mem_write;
  logic [1:0]    sel;
  logic [31:0]   addr, wdata;
  logic          ram_we, timer_we, hd_req, hd_ack, stall, err, state_dbg;
  logic [31:0]   ram_addr, ram_wdata, timer_wdata, hd_addr, hd_wdata;
  logic [CW-1:0] wr_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_cnt      = 0;
  logic exp_err    = 1'b0;
  logic [65:0] exp_q[$];

  mem_write_dispatcher #(.HD_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .sel(sel), .addr(addr),
    .wdata(wdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .timer_we(timer_we), .timer_wdata(timer_wdata), .hd_req(hd_req),
    .hd_addr(hd_addr), .hd_wdata(hd_wdata), .hd_ack(hd_ack), .stall(stall),
    .err(err), .wr_count(wr_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: every write presented by the DUT must match the oldest expected store
  logic        prev_hd = 1'b0;
  int          n_act;
  logic [65:0] got;

  task automatic pop_cmp(input string name, input logic [65:0] g);
    if (exp_q.size() == 0) chk({name, "_unexpected"}, g, 66'd0);
    else chk(name, g, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      n_act = int'(ram_we) + int'(timer_we) + int'(hd_req && !prev_hd);
      if (n_act > 0) chk("one_target", 66'(n_act > 1), 66'd0);
      if (ram_we) pop_cmp("ram_write", {2'd1, ram_addr, ram_wdata});
      if (timer_we) pop_cmp("timer_write", {2'd2, 32'd0, timer_wdata});
      if (hd_req && !prev_hd) pop_cmp("hd_write", {2'd3, hd_addr, hd_wdata});
    end
    prev_hd = hd_req;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mem_write = 1'b0;
    hd_ack    = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_wr_count"}, wr_count, 66'(exp_cnt % (1 << CW)));
    chk({tag, "_err"}, err, exp_err);
  endtask

  task automatic issue(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1;
    sel       = s;
    addr      = a;
    wdata     = d;
    #1;
    chk("stall_req", stall, s == 2'b11);
    case (s)
      2'b01: begin exp_q.push_back({2'd1, a, d}); exp_cnt++; end
      2'b10: begin exp_q.push_back({2'd2, 32'd0, d}); exp_cnt++; end
      2'b11: exp_q.push_back({2'd3, a, d});
      default: exp_err = 1'b1;
    endcase
    tick();
  endtask

  // ack_at: hd_req cycle (1-based) on which hd_ack is driven; > T means never
  task automatic hd_store(input logic [31:0] a, input logic [31:0] d, input int ack_at);
    issue(2'b11, a, d);
    for (int k = 1; k <= T; k++) begin
      mem_write = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      addr      = $urandom;
      wdata     = $urandom;
      hd_ack    = (k == ack_at);
      #1;
      chk("hd_req_held", hd_req, 66'd1);
      chk("stall_wait", stall, 66'd1);
      chk("hd_frozen", {2'd3, hd_addr, hd_wdata}, {2'd3, a, d});
      tick();
      if (k == ack_at) break;
    end
    hd_ack    = 1'b0;
    mem_write = 1'b0;
    #1;
    chk("hd_req_drop", hd_req, 66'd0);
    chk("stall_after", stall, 66'd0);
    if (ack_at <= T) exp_cnt++;
    else exp_err = 1'b1;
    check_regs("hd_done");
  endtask

  initial begin
    reset = 1'b1; mem_write = 1'b0; sel = 2'b00; addr = '0; wdata = '0; hd_ack = 1'b0;
    repeat (2) tick();
    chk("reset_flags", {ram_we, timer_we, hd_req, err, stall, state_dbg}, 66'd0);
    chk("reset_ram", {2'd0, ram_addr, ram_wdata}, 66'd0);
    chk("reset_tmr_cnt", {timer_wdata, wr_count}, 66'd0);
    chk("reset_hd", {2'd0, hd_addr, hd_wdata}, 66'd0);
    reset = 1'b0;
    tick();

    // single RAM store
    issue(2'b01, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("ram_pulse", ram_we, 66'd1);
    idle(1);
    chk("ram_pulse_end", ram_we, 66'd0);
    check_regs("ram1");

    // back-to-back RAM, timer, RAM
    issue(2'b01, 32'h1, 32'h1);
    issue(2'b10, 32'h2, 32'h2);
    issue(2'b01, 32'h3, 32'h3);
    idle(1);
    check_regs("b2b");

    // HD acked on its 5th request cycle, then HD timeout, then a normal RAM store
    hd_store(32'h400, 32'h1234_5678, 5);
    hd_store(32'h500, 32'hCAFE_0001, T + 5);
    idle(2);
    check_regs("after_to");
    issue(2'b01, 32'h20, 32'h55AA_55AA);
    idle(1);
    check_regs("ram_after_to");

    // fresh error state: illegal select and a stray hd_ack in IDLE
    reset = 1'b1; tick(); reset = 1'b0; exp_cnt = 0; exp_err = 1'b0;
    issue(2'b00, 32'h30, 32'h30);
    idle(1);
    check_regs("sel00");
    hd_ack = 1'b1;
    tick();
    hd_ack = 1'b0;
    #1;
    chk("ack_idle_req", {hd_req, state_dbg}, 66'd0);
    check_regs("ack_idle");

    // reset in the middle of an HD wait
    issue(2'b01, 32'h40, 32'h40);
    issue(2'b11, 32'h800, 32'h8888_0000);
    mem_write = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0; exp_err = 1'b0;
    chk("rst_mid_hd", {hd_req, stall, state_dbg}, 66'd0);
    check_regs("rst_mid_hd");
    idle(1);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) issue(2'b01, $urandom, $urandom);
      else if (op <= 6) issue(2'b10, $urandom, $urandom);
      else if (op <= 8) hd_store($urandom, $urandom, $urandom_range(1, T + 2));
      else if ($urandom_range(0, 3) == 0) issue(2'b00, $urandom, $urandom);
      else begin
        mem_write = 1'b0;
        hd_ack    = 1'b1;
        tick();
        hd_ack    = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      check_regs("rand");
    end

    idle(3);
    chk("queue_empty", 66'(exp_q.size()), 66'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
